// File: rtl/uart_tx.sv
// UART transmitter: start bit, data_bit_size data bits LSB first, optional parity, stop time.
// Bits are paced by a 16x bd_tick strobe. Define UART_TX_PARITY_EN to insert a parity bit.
module uart_tx #(
    parameter int data_bit_size = 8,
    parameter int stop_bit_size = 16,
    parameter int parity_odd    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bd_tick,
    input  logic       tx_start,
    input  logic [7:0] w_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int CNT_W = (stop_bit_size > 16) ? 6 : 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(stop_bit_size - 1);
    localparam logic [2:0]       DATA_LAST = 3'(data_bit_size - 1);
    localparam logic [7:0]       DATA_MASK = 8'((1 << data_bit_size) - 1);

    generate
        if (data_bit_size < 5 || data_bit_size > 8 || stop_bit_size < 1 ||
            stop_bit_size > 64 || parity_odd < 0 || parity_odd > 1) begin : g_bad_cfg
            $error("uart_tx: unsupported parameter combination");
        end
    endgenerate

    logic [2:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [7:0]       buf_data;
    logic             buf_full;
    logic             tx_q;
    logic             done_q;
    logic             accept;
    logic             stop_end;
    logic             do_load;

    assign tx_ready = ~buf_full;
    assign tx_busy  = (state != S_IDLE);
    assign tx_done  = done_q;
    assign tx       = tx_q;

    // Accept needs an empty buffer, so it can never coincide with a drain.
    assign accept   = tx_start & ~buf_full;
    assign stop_end = (state == S_STOP) & bd_tick & (tick_cnt == STOP_LAST);
    assign do_load  = buf_full & ((state == S_IDLE) | stop_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= 8'h00;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= w_data & DATA_MASK;
        end else if (do_load) begin
            buf_full <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // Parity is fixed at load time from the already-masked buffered byte.
    always_ff @(posedge clk) begin
        if (reset)
            par_q <= 1'b0;
        else if (do_load)
            par_q <= (^buf_data) ^ (parity_odd != 0);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (buf_full) begin
                        shift_reg <= buf_data;
                        tick_cnt  <= '0;
                        state     <= S_START;
                        tx_q      <= 1'b0;
                    end
                end
                S_START: begin
                    if (bd_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= 3'd0;
                            state    <= S_DATA;
                            tx_q     <= shift_reg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (bd_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= shift_reg >> 1;
                            if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state <= S_PARITY;
                                tx_q  <= par_q;
`else
                                state <= S_STOP;
                                tx_q  <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_q    <= shift_reg[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bd_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            state    <= S_STOP;
                            tx_q     <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (bd_tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                            done_q   <= 1'b1;
                            // A waiting byte starts straight away so frames run back to back.
                            if (buf_full) begin
                                shift_reg <= buf_data;
                                state     <= S_START;
                                tx_q      <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: accepted bytes are queued by a buffer model; a monitor rebuilds the
// expected line level from the bd_tick count inside each frame and checks every cycle.
module tb_uart_tx;

    localparam int DBITS = 8;
    localparam int STOPT = 16;
    localparam int P_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_TICKS = (1 + DBITS + PBITS) * 16 + STOPT;
    localparam logic [7:0] MASK = 8'((1 << DBITS) - 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bd_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       tx_ready, tx_busy, tx_done, tx;

    uart_tx #(.data_bit_size(DBITS), .stop_bit_size(STOPT), .parity_odd(P_ODD)) dut (
        .clk(clk), .reset(reset), .bd_tick(bd_tick), .tx_start(tx_start), .w_data(w_data),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected line level k ticks into a frame carrying byte c.
    function automatic logic exp_bit(input int kk, input logic [7:0] c);
        int seg;
        seg = kk / 16;
        if (seg == 0) return 1'b0;
        if (seg <= DBITS) return c[seg-1];
        if (PBITS == 1 && seg == DBITS + 1) return (^(c & MASK)) ^ (P_ODD != 0);
        return 1'b1;
    endfunction

    // Tick source: fixed period or random.
    int tick_period = 1;
    bit tick_rand = 1'b0;
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            if (tick_rand) bd_tick = ($urandom_range(2) == 0);
            else           bd_tick = ((phase % tick_period) == 0);
        end
    end

    // Reference model / scoreboard state.
    logic [7:0] expq[$];
    logic [7:0] cur = 8'h00;
    bit in_frame = 1'b0;
    bit armed = 1'b0;
    int k = 0;
    int mbuf_age = 0;
    int cyc = 0;
    int fstart = 0;
    int fperiod = 0;
    int frames = 0;
    int accepted = 0;

    always @(negedge clk) begin
        bit ended;
        ended = 1'b0;
        cyc++;
        if (armed) begin
            if (in_frame && k == FRAME_TICKS) begin
                chk("tx_done_end", tx_done, 1'b1);
                if (fperiod > 0) begin
                    int dur;
                    dur = cyc - fstart;
                    chk("frame_cycles", (dur >= (FRAME_TICKS - 1) * fperiod + 1) &&
                                        (dur <= FRAME_TICKS * fperiod), 1'b1);
                    if (fperiod == 1) chkn("frame_len", dur, FRAME_TICKS);
                end
                in_frame = 1'b0;
                frames++;
                ended = 1'b1;
            end else begin
                chk("tx_done_low", tx_done, 1'b0);
            end

            if (in_frame) begin
                chk("tx_bit", tx, exp_bit(k, cur));
            end else if (tx === 1'b0) begin
                if (expq.size() == 0) begin
                    chk("spurious_start", tx, 1'b1);
                end else begin
                    cur = expq.pop_front();
                    in_frame = 1'b1;
                    k = 0;
                    fstart = cyc;
                    fperiod = tick_rand ? 0 : tick_period;
                end
            end else if (expq.size() != 0 && ended) begin
                chk("gap_free", tx, 1'b0);
            end else if (expq.size() != 0 && mbuf_age >= 1) begin
                chk("load_latency", tx, 1'b0);
            end else begin
                chk("tx_idle", tx, 1'b1);
            end

            if (expq.size() != 0) mbuf_age++;
            chk("tx_ready", tx_ready, expq.size() == 0);
            chk("tx_busy", tx_busy, in_frame);
        end

        // Inputs now stable will be sampled at the coming rising edge.
        if (reset) begin
            if (armed) accepted -= expq.size() + (in_frame ? 1 : 0);
            armed = 1'b1;
            in_frame = 1'b0;
            expq.delete();
            k = 0;
        end else if (armed) begin
            if (in_frame && bd_tick) k++;
            if (tx_start && expq.size() == 0) begin
                expq.push_back(w_data & MASK);
                mbuf_age = 0;
                accepted++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic write(input logic [7:0] b);
        @(posedge clk); #1;
        tx_start = 1'b1;
        w_data = b;
        @(posedge clk); #1;
        tx_start = 1'b0;
        w_data = 8'($urandom);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((in_frame || expq.size() != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", n < limit, 1'b1);
        if (n >= limit) pulse_reset(1);
        cycles(3);
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for three cycles, then idle.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cycles(20);

        // Single frame, tick every cycle.
        tick_period = 1;
        write(8'hA5);
        wait_idle(2000);

        // Back-to-back frames; 0x33 arrives while the buffer holds 0x0F.
        write(8'h55);
        cycles(40);
        write(8'h0F);
        cycles(10);
        write(8'h33);
        wait_idle(3000);

        // Abort 0xFF in data bit 3, then send 0x81.
        write(8'hFF);
        cycles(70);
        pulse_reset(1);
        cycles(5);
        write(8'h81);
        wait_idle(2000);

        // Slow ticks.
        tick_period = 4;
        write(8'h01);
        wait_idle(5000);
        write(8'h07);
        wait_idle(5000);

        // Randomised traffic and tick pacing.
        for (int g = 0; g < 8; g++) begin
            wait_idle(8000);
            tick_rand = ($urandom_range(3) == 0);
            tick_period = $urandom_range(1, 3);
            for (int i = 0; i < 5; i++) begin
                cycles($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 250));
                write(8'($urandom));
            end
        end
        wait_idle(8000);
        tick_rand = 1'b0;

        chkn("queue_empty", expq.size(), 0);
        chkn("frames_sent", frames, accepted);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
